// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed seven-segment scanner with
// frame-boundary commits, zero blanking, floating sign and blink.
module display_scan_ctrl #(
  parameter int DIGITS     = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 64,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [4*DIGITS-1:0]       value_i,
  input  logic                      sign_i,
  input  logic [DIGITS-1:0]         blink_i,
  input  logic [$clog2(DIGITS)-1:0] dp_pos_i,
  input  logic                      lzb_i,
  input  logic                      load_i,
  output logic                      ready_o,
  output logic [7:0]                seg_o,
  output logic [DIGITS-1:0]         an_o,
  output logic                      ovf_o
);

  localparam int IW = $clog2(DIGITS);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [PW-1:0] LAST_PS  = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] LAST_FR  = FW'(BLINK_DIV - 1);
  localparam logic          LVL_OFF  = (ACTIVE_LOW != 0);

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [FW-1:0]       frm_q, frm_d;
  logic                phase_q, phase_d;
  logic                ready_q, ready_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic [4*DIGITS-1:0] dval_q, sval_q;
  logic                dsign_q, ssign_q;
  logic [DIGITS-1:0]   dblink_q, sblink_q;
  logic [IW-1:0]       ddp_q, sdp_q;
  logic                dlzb_q, slzb_q;

  logic                tc;
  logic                wrap;
  logic                accept;
  logic [3:0]          nib;
  logic                blk;
  logic [DIGITS-1:0]   hot;
  logic [7:0]          lit;
  int                  hv;
  int                  hv_sh;
  int                  pos;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  // Index of the highest digit that survives leading-zero blanking.
  function automatic int top_vis(
    input logic [4*DIGITS-1:0] v,
    input logic [IW-1:0]       dp,
    input logic                lz
  );
    int h;
    h = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!lz || i <= int'(dp) || v[i*4 +: 4] != 4'h0) h = i;
    end
    return h;
  endfunction

  always_comb begin
    tc      = (presc_q == LAST_PS);
    wrap    = tc && (idx_q == LAST_IDX);
    accept  = load_i && ready_q;

    presc_d = tc ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tc) idx_d = wrap ? '0 : idx_q + 1'b1;

    frm_d   = frm_q;
    phase_d = phase_q;
    if (wrap) begin
      if (frm_q == LAST_FR) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    // A load landing on the wrap cycle waits for the next wrap.
    ready_d = ready_q;
    if (accept) ready_d = 1'b0;
    else if (wrap) ready_d = 1'b1;

    hv_sh = top_vis(sval_q, sdp_q, slzb_q);
    ovf_d = ovf_q;
    if (wrap) ovf_d = ssign_q && !(slzb_q && hv_sh < DIGITS - 1);
  end

  always_comb begin
    nib = '0;
    blk = 1'b0;
    hot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib    = dval_q[i*4 +: 4];
        blk    = dblink_q[i];
        hot[i] = 1'b1;
      end
    end

    hv  = top_vis(dval_q, ddp_q, dlzb_q);
    pos = int'(idx_q);
    lit = 8'h00;
    if (phase_q || !blk) begin
      if (pos <= hv) lit = {idx_q == ddp_q, hex7(nib)};
      else if (dsign_q && dlzb_q && pos == hv + 1) lit = 8'h40;
    end

    seg_d = lit ^ {8{LVL_OFF}};
    an_d  = hot ^ {DIGITS{LVL_OFF}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      phase_q <= 1'b1;
      ready_q <= 1'b1;
      ovf_q   <= 1'b0;
      seg_q   <= {8{LVL_OFF}};
      an_q    <= {DIGITS{LVL_OFF}};
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sval_q   <= '0;
      ssign_q  <= 1'b0;
      sblink_q <= '0;
      sdp_q    <= '0;
      slzb_q   <= 1'b0;
    end else if (accept) begin
      sval_q   <= value_i;
      ssign_q  <= sign_i;
      sblink_q <= blink_i;
      sdp_q    <= dp_pos_i;
      slzb_q   <= lzb_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dval_q   <= '0;
      dsign_q  <= 1'b0;
      dblink_q <= '0;
      ddp_q    <= '0;
      dlzb_q   <= 1'b0;
    end else if (wrap) begin
      dval_q   <= sval_q;
      dsign_q  <= ssign_q;
      dblink_q <= sblink_q;
      ddp_q    <= sdp_q;
      dlzb_q   <= slzb_q;
    end
  end

  assign ready_o = ready_q;
  assign ovf_o   = ovf_q;
  assign seg_o   = seg_q;
  assign an_o    = an_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed plan items plus random loads,
// checked cycle by cycle against a frame-arithmetic model.
module tb_display_scan_ctrl;

  localparam int DIGITS     = 4;
  localparam int SCAN_DIV   = 2;
  localparam int BLINK_DIV  = 2;
  localparam int ACTIVE_LOW = 1;
  localparam int FRAME      = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] value_i;
  logic        sign_i;
  logic [3:0]  blink_i;
  logic [1:0]  dp_pos_i;
  logic        lzb_i;
  logic        load_i;
  logic        ready_o;
  logic [7:0]  seg_o;
  logic [3:0]  an_o;
  logic        ovf_o;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV),
    .BLINK_DIV(BLINK_DIV), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .value_i(value_i), .sign_i(sign_i),
    .blink_i(blink_i), .dp_pos_i(dp_pos_i),
    .lzb_i(lzb_i), .load_i(load_i),
    .ready_o(ready_o), .seg_o(seg_o),
    .an_o(an_o), .ovf_o(ovf_o)
  );

  typedef struct packed {
    logic [15:0] val;
    logic        sign;
    logic [3:0]  blink;
    logic [1:0]  dp;
    logic        lzb;
  } st_t;

  st_t        m_disp, m_sh;
  bit         m_pend;
  int         ec;
  logic [7:0] exp_seg;
  logic [3:0] exp_an;
  logic [7:0] seen [DIGITS];
  int         total = 0;
  int         bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Standard active-low hex glyphs, dp bit high (off).
  function automatic logic [7:0] glyph_al(logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  // Number of shown digits counted from the right.
  function automatic int sig_n(st_t s);
    int n;
    n = DIGITS;
    if (s.lzb) begin
      n = int'(s.dp) + 1;
      for (int i = 0; i < DIGITS; i++)
        if (s.val[i*4 +: 4] != 4'h0 && i + 1 > n) n = i + 1;
    end
    return n;
  endfunction

  function automatic bit ovf_of(st_t s);
    return s.sign && sig_n(s) >= DIGITS;
  endfunction

  function automatic logic [7:0] render(st_t s, int d, bit on);
    int n;
    logic [7:0] al;
    n  = sig_n(s);
    al = 8'hFF;
    if (on || !s.blink[d]) begin
      if (d < n) begin
        al = glyph_al(s.val[d*4 +: 4]);
        if (d == int'(s.dp)) al[7] = 1'b0;
      end else if (s.sign && d == n) begin
        al = 8'hBF;
      end
    end
    return al;
  endfunction

  task automatic mdl_edge();
    int c, d;
    bit on, rdy0;
    ec++;
    c  = ec - 1;
    d  = (c / SCAN_DIV) % DIGITS;
    on = (((c / FRAME) / BLINK_DIV) % 2) == 0;
    exp_seg = render(m_disp, d, on);
    exp_an  = ~(4'b0001 << d);
    rdy0 = !m_pend;
    if (ec % FRAME == 0 && m_pend) begin
      m_disp = m_sh;
      m_pend = 1'b0;
    end
    if (load_i && rdy0) begin
      m_sh   = {value_i, sign_i, blink_i, dp_pos_i, lzb_i};
      m_pend = 1'b1;
    end
  endtask

  task automatic cyc();
    logic [3:0] oh;
    @(posedge clk);
    mdl_edge();
    @(negedge clk);
    chk("an", 32'(an_o), 32'(exp_an));
    chk("seg", 32'(seg_o), 32'(exp_seg));
    chk("ready", 32'(ready_o), 32'(!m_pend));
    chk("ovf", 32'(ovf_o), 32'(ovf_of(m_disp)));
    for (int i = 0; i < DIGITS; i++) begin
      oh = 4'b0001 << i;
      if (an_o == ~oh) seen[i] = seg_o;
    end
  endtask

  task automatic load_cyc(logic [15:0] v, bit s, logic [3:0] b,
                          logic [1:0] dp, bit lz);
    value_i  = v;
    sign_i   = s;
    blink_i  = b;
    dp_pos_i = dp;
    lzb_i    = lz;
    load_i   = 1'b1;
    cyc();
    load_i   = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_seg", 32'(seg_o), 32'hFF);
    chk("rst_an", 32'(an_o), 32'hF);
    chk("rst_ready", 32'(ready_o), 32'h1);
    chk("rst_ovf", 32'(ovf_o), 32'h0);
    @(negedge clk);
    ec     = 0;
    m_disp = '0;
    m_sh   = '0;
    m_pend = 1'b0;
    for (int i = 0; i < DIGITS; i++) seen[i] = 8'h00;
    reset_n = 1'b1;
  endtask

  initial begin
    int off0, lit0, off1, lz;
    logic [15:0] v;
    load_i = 1'b0; value_i = '0; sign_i = 1'b0;
    blink_i = '0; dp_pos_i = '0; lzb_i = 1'b0;

    do_reset();
    repeat (16) cyc();
    chk("idle_d0", 32'(seen[0]), 32'h40);
    chk("idle_d1", 32'(seen[1]), 32'hC0);
    chk("idle_d2", 32'(seen[2]), 32'hC0);
    chk("idle_d3", 32'(seen[3]), 32'hC0);

    repeat (3) cyc();
    load_cyc(16'h1234, 1'b0, 4'h0, 2'd0, 1'b0);
    chk("hs_busy", 32'(ready_o), 32'h0);
    load_cyc(16'h5678, 1'b0, 4'h0, 2'd0, 1'b0);
    repeat (20) cyc();
    chk("hs_d0", 32'(seen[0]), 32'h19);
    chk("hs_d1", 32'(seen[1]), 32'hB0);
    chk("hs_d2", 32'(seen[2]), 32'hA4);
    chk("hs_d3", 32'(seen[3]), 32'hF9);

    load_cyc(16'h0042, 1'b1, 4'h0, 2'd0, 1'b1);
    repeat (20) cyc();
    chk("bl_d3", 32'(seen[3]), 32'hFF);
    chk("bl_d2", 32'(seen[2]), 32'hBF);
    chk("bl_d1", 32'(seen[1]), 32'h99);
    chk("bl_d0", 32'(seen[0]), 32'h24);
    chk("bl_ovf", 32'(ovf_o), 32'h0);

    load_cyc(16'h9042, 1'b1, 4'h0, 2'd0, 1'b1);
    repeat (20) cyc();
    chk("ov_flag", 32'(ovf_o), 32'h1);
    chk("ov_d3", 32'(seen[3]), 32'h90);
    chk("ov_d2", 32'(seen[2]), 32'hC0);

    load_cyc(16'h0042, 1'b0, 4'b0001, 2'd0, 1'b1);
    repeat (16) cyc();
    off0 = 0; lit0 = 0; off1 = 0;
    repeat (64) begin
      cyc();
      if (an_o == 4'b1110 && seg_o == 8'hFF) off0++;
      if (an_o == 4'b1110 && seg_o == 8'h24) lit0++;
      if (an_o == 4'b1101 && seg_o == 8'hFF) off1++;
    end
    chk("blink_off0", 32'(off0), 32'd8);
    chk("blink_lit0", 32'(lit0), 32'd8);
    chk("blink_d1", 32'(off1), 32'd0);

    while ((ec + 1) % FRAME != 0) cyc();
    load_cyc(16'h0777, 1'b0, 4'h0, 2'd1, 1'b1);
    chk("wrapld_busy", 32'(ready_o), 32'h0);
    repeat (7) cyc();
    chk("wrapld_hold", 32'(ready_o), 32'h0);
    cyc();
    chk("wrapld_commit", 32'(ready_o), 32'h1);

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      v  = 16'($urandom);
      lz = $urandom_range(0, 4);
      for (int k = 0; k < lz; k++) v[15-4*k -: 4] = 4'h0;
      value_i  = v;
      sign_i   = 1'($urandom);
      blink_i  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      dp_pos_i = 2'($urandom);
      lzb_i    = ($urandom_range(0, 3) != 0);
      load_i   = ($urandom_range(0, 5) == 0);
      cyc();
    end
    load_i = 1'b0;

    repeat (16) cyc();
    while (ec % FRAME != 1) cyc();
    load_cyc(16'hABCD, 1'b0, 4'h0, 2'd0, 1'b0);
    cyc();
    cyc();
    chk("mp_pending", 32'(ready_o), 32'h0);
    do_reset();
    repeat (12) cyc();
    chk("mp_d0", 32'(seen[0]), 32'h40);
    chk("mp_d1", 32'(seen[1]), 32'hC0);
    chk("mp_d2", 32'(seen[2]), 32'hC0);
    chk("mp_d3", 32'(seen[3]), 32'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
